// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-GPR pending-write counters that gate issue on
// read-after-write hazards and on write-after-write counter overflow.
`timescale 1ns/1ps

module issue_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        IdValid,
  output logic        IdReady,
  input  logic        Rs1ReadEnable,
  input  logic [4:0]  Rs1Addr,
  input  logic        Rs2ReadEnable,
  input  logic [4:0]  Rs2Addr,
  input  logic        RdWriteEnable,
  input  logic [4:0]  RdAddr,
  input  logic        ExReady,
  output logic        IssueFire,
  input  logic        WbValid,
  input  logic [4:0]  WbAddr,
  input  logic        Flush,
  output logic        Busy,
  output logic        WbUnderflow,
  output logic [31:0] StallCycles
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned STALL_W  = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Entry 0 exists only so address lookups stay in range; it is held at zero.
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  logic raw1;
  logic raw2;
  logic ovf;
  logic underflow_hit;
  logic stall_hit;
  logic busy_any;

  // Hazard lookup against registered counters only; x0 never blocks.
  always_comb begin
    raw1 = Rs1ReadEnable && (Rs1Addr != ADDR_W'(0)) && (cnt_q[Rs1Addr] != '0);
    raw2 = Rs2ReadEnable && (Rs2Addr != ADDR_W'(0)) && (cnt_q[Rs2Addr] != '0);
    ovf  = RdWriteEnable && (RdAddr  != ADDR_W'(0)) && (cnt_q[RdAddr] == CNT_MAX);
  end

  // Issue handshake: readiness does not depend on IdValid.
  always_comb begin
    IdReady   = ExReady && !Flush && !raw1 && !raw2 && !ovf;
    IssueFire = IdValid && IdReady;
  end

  // Per-register increment (issue of a writer) and decrement (writeback) requests.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = IssueFire && RdWriteEnable && (RdAddr == ADDR_W'(r));
      dec_vec[r] = WbValid && (WbAddr == ADDR_W'(r)) && (cnt_q[r] != '0);
    end
  end

  // Counter next-state; flush wins over any same-cycle issue or writeback.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (Flush || (r == 0)) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Pending-write counter storage.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Busy reflects any outstanding write in the registered counters.
  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_any = busy_any | (cnt_q[r] != '0);
    end
    Busy = busy_any;
  end

  // Writeback to an idle register (x0 excluded, flush cycles ignored).
  always_comb begin
    underflow_hit = WbValid && !Flush && (WbAddr != ADDR_W'(0)) && (cnt_q[WbAddr] == '0);
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      WbUnderflow <= 1'b0;
    end else if (underflow_hit) begin
      WbUnderflow <= 1'b1;
    end
  end

  // A stall cycle is a presented instruction that is not accepted.
  always_comb begin
    stall_hit = IdValid && !IdReady && (StallCycles != {STALL_W{1'b1}});
  end

  // Saturating stall-cycle counter; survives flush.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      StallCycles <= '0;
    end else if (stall_hit) begin
      StallCycles <= StallCycles + STALL_W'(1);
    end
  end

endmodule
